// File: rtl/branch_resolve_unit_if.sv
// Branch-resolution bus between the ID/EX pipeline control and the resolve unit.
// The slave modport is the resolve unit; the master modport is the pipeline/predictor side.
interface branch_resolve_unit_if;
  logic        id_branch_i;
  logic        id_predict_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_target_i;
  logic        stall_i;
  logic        ex_taken_i;
  logic        branch_o;
  logic        update_o;
  logic        result_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] br_count_o;
  logic [15:0] mis_count_o;

  modport slave (
    input  id_branch_i, id_predict_i, id_pc_i, id_target_i, stall_i, ex_taken_i,
    output branch_o, update_o, result_o, flush_o, redirect_pc_o, br_count_o, mis_count_o
  );

  modport master (
    output id_branch_i, id_predict_i, id_pc_i, id_target_i, stall_i, ex_taken_i,
    input  branch_o, update_o, result_o, flush_o, redirect_pc_o, br_count_o, mis_count_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID/EX branch holding register plus EX-stage resolution: predictor update strobes,
// mispredict flush with redirect PC, and saturating resolve/mispredict counters.
module branch_resolve_unit (
  input  logic                  clk_i,
  input  logic                  rst_i,
  branch_resolve_unit_if.slave  bus
);

  logic        r_ex_valid;
  logic        r_ex_pred;
  logic [31:0] r_ex_pc_plus4;
  logic [31:0] r_ex_target;
  logic [15:0] r_br_count;
  logic [15:0] r_mis_count;

  logic        w_resolve;
  logic        w_flush;
  logic [31:0] w_redirect;

  // Resolution is purely combinational off the held branch and this cycle's outcome.
  assign w_resolve  = r_ex_valid & ~bus.stall_i;
  assign w_flush    = w_resolve & (bus.ex_taken_i ^ r_ex_pred);
  assign w_redirect = bus.ex_taken_i ? r_ex_target : r_ex_pc_plus4;

  assign bus.branch_o      = w_resolve;
  assign bus.update_o      = w_resolve & bus.ex_taken_i;
  assign bus.result_o      = w_resolve & r_ex_pred;
  assign bus.flush_o       = w_flush;
  assign bus.redirect_pc_o = w_flush ? w_redirect : 32'd0;
  assign bus.br_count_o    = r_br_count;
  assign bus.mis_count_o   = r_mis_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex_valid    <= 1'b0;
      r_ex_pred     <= 1'b0;
      r_ex_pc_plus4 <= 32'd0;
      r_ex_target   <= 32'd0;
    end else if (!bus.stall_i) begin
      if (w_flush) begin
        // Wrong-path ID instruction is dropped; only the valid bit matters.
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid    <= bus.id_branch_i;
        r_ex_pred     <= bus.id_predict_i;
        r_ex_pc_plus4 <= bus.id_pc_i + 32'd4;
        r_ex_target   <= bus.id_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_br_count  <= 16'd0;
      r_mis_count <= 16'd0;
    end else begin
      if (w_resolve && r_br_count != 16'hFFFF)
        r_br_count <= r_br_count + 16'd1;
      if (w_flush && r_mis_count != 16'hFFFF)
        r_mis_count <= r_mis_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit with a queue-based scoreboard
// fed by a transaction-level model of the in-flight branch.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if bus();

  branch_resolve_unit dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          stamp;
    logic        upd;
    logic        res;
    logic        fl;
    logic [31:0] rpc;
    logic [15:0] brc;
    logic [15:0] misc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  bit   done = 1'b0;

  // Model: at most one branch in flight between ID and EX.
  bit          m_v = 1'b0;
  bit          m_pred;
  logic [31:0] m_pc4, m_tgt;
  int          m_br = 0, m_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_br = 0; m_mis = 0;
    q.delete();
  endtask

  // One clock cycle: drive ID/EX inputs, predict the response, advance the model.
  task automatic cyc(input logic br, input logic pr, input logic [31:0] pc,
                     input logic [31:0] tg, input logic st, input logic tk);
    exp_t e;
    bit   mis;
    cyc_n++;
    bus.id_branch_i = br; bus.id_predict_i = pr; bus.id_pc_i = pc;
    bus.id_target_i = tg; bus.stall_i = st;     bus.ex_taken_i = tk;
    if (!st) begin
      mis = m_v && (tk != m_pred);
      if (m_v) begin
        e.stamp = cyc_n; e.upd = tk; e.res = m_pred; e.fl = mis;
        e.rpc   = mis ? (tk ? m_tgt : m_pc4) : 32'd0;
        e.brc   = 16'(m_br); e.misc = 16'(m_mis);
        q.push_back(e);
        if (m_br < 65535) m_br++;
        if (mis && m_mis < 65535) m_mis++;
      end
      if (mis) m_v = 1'b0;
      else begin
        m_v = br; m_pred = pr; m_pc4 = pc + 32'd4; m_tgt = tg;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: sample mid-cycle, compare against the oldest expected resolution.
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (bus.branch_o) begin
        if (q.size() == 0) chk("spurious_branch", 1, 0);
        else begin
          e = q.pop_front();
          chk("res_cycle", cyc_n, e.stamp);
          chk("update",    bus.update_o, e.upd);
          chk("result",    bus.result_o, e.res);
          chk("flush",     bus.flush_o, e.fl);
          chk("redirect",  bus.redirect_pc_o, e.rpc);
          chk("br_count",  bus.br_count_o, e.brc);
          chk("mis_count", bus.mis_count_o, e.misc);
        end
      end else begin
        chk("idle_outputs", {bus.update_o, bus.result_o, bus.flush_o, bus.redirect_pc_o}, 0);
        if (q.size() != 0 && q[0].stamp <= cyc_n) begin
          chk("missed_branch", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.id_branch_i = 0; bus.id_predict_i = 0; bus.id_pc_i = 0;
    bus.id_target_i = 0; bus.stall_i = 0;      bus.ex_taken_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.branch_o, bus.flush_o, bus.redirect_pc_o,
                          bus.br_count_o, bus.mis_count_o}, 0);
    rst_n = 1'b1;

    // Correct taken, then mispredict not-taken with an ID branch that must be dropped.
    cyc(1, 1, 32'h100, 32'h200, 0, 0);
    cyc(1, 1, 32'h100, 32'h200, 0, 1);
    cyc(1, 0, 32'h500, 32'h600, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Mispredict taken.
    cyc(1, 0, 32'h30, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Held 3 cycles in EX, resolves once on release.
    cyc(1, 1, 32'h300, 32'h400, 0, 0);
    cyc(1, 0, 32'h700, 32'h800, 1, 0);
    cyc(1, 0, 32'h700, 32'h800, 1, 0);
    cyc(1, 0, 32'h700, 32'h800, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // PC+4 wrap on a not-taken mispredict.
    cyc(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} >> 0;
      pc[1:0] = 2'b00;
      cyc(($urandom_range(0, 9) < 6), $urandom_range(0, 1), pc,
          {$urandom(), 2'b00} >> 0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    // Reset while a mispredict is pending in EX.
    cyc(1, 1, 32'h900, 32'hA00, 0, 0);
    bus.id_branch_i = 0; bus.stall_i = 0; bus.ex_taken_i = 0;
    #1;
    chk("pre_reset_flush", bus.flush_o, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", {bus.branch_o, bus.update_o, bus.result_o, bus.flush_o,
                                bus.redirect_pc_o, bus.br_count_o, bus.mis_count_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h20, 32'h80, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Drive the resolve counter into saturation with correct predictions.
    while (m_br < 65535) cyc(1, 1, 32'h1000, 32'h2000, 0, 1);
    repeat (3) cyc(1, 1, 32'h1000, 32'h2000, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("br_count_saturated", bus.br_count_o, 16'hFFFF);
    chk("mis_count_final", bus.mis_count_o, 16'(m_mis));

    @(negedge clk); #1;
    done = 1'b1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout cycle=%0d actual=running expected=finished", cyc_n);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous reset, active-low; takes effect on its falling edge.
REQ-004 id_branch_i  input  1  the ID-stage instruction is a conditional branch.
REQ-005 id_predict_i  input  1  predictor direction for the ID branch: 1 = taken.
REQ-006 id_pc_i  input  32  PC of the ID-stage instruction.
REQ-007 id_target_i  input  32  computed branch target of the ID-stage instruction.
REQ-008 stall_i  input  1  pipeline stall; freezes the ID/EX holding register.
REQ-009 ex_taken_i  input  1  actual branch outcome in EX: 1 = taken.
REQ-010 branch_o  output  1  a branch resolves this cycle; drives the predictor's branch-enable input.
REQ-011 update_o  output  1  actual outcome of the resolving branch; drives the predictor's update input.
REQ-012 result_o  output  1  direction originally predicted for the resolving branch; drives the predictor's result input.
REQ-013 flush_o  output  1  misprediction; the IF/ID instructions are wrong-path.
REQ-014 redirect_pc_o  output  32  corrected fetch PC; valid only while flush_o=1, otherwise 0.
REQ-015 br_count_o  output  16  number of branches resolved.
REQ-016 mis_count_o  output  16  number of mispredictions.

Function
REQ-017 The ID/EX holding register SHALL store ex_valid, ex_pred, ex_pc_plus4 (id_pc_i+4, modulo 2^32) and ex_target.
REQ-018 Capture: if stall_i=0 and flush_o=0, the register SHALL load ex_valid<=id_branch_i and the other fields from the ID inputs on the clock edge.
REQ-019 Stall: while stall_i=1, all holding-register fields and both counters SHALL hold their values.
REQ-020 Flush priority: if flush_o=1 and stall_i=0, ex_valid SHALL clear to 0 on the edge, inserting a bubble, and the ID inputs SHALL be discarded.
REQ-021 Resolution: a branch resolves in any cycle with ex_valid=1 and stall_i=0; resolution outputs are combinational in that cycle (zero-cycle latency).
REQ-022 A stalled branch SHALL resolve exactly once, in the first cycle in which stall_i=0.
REQ-023 When a branch resolves: branch_o=1, update_o=ex_taken_i, result_o=ex_pred.
REQ-024 When no branch resolves: branch_o, update_o, result_o and flush_o SHALL all be 0.
REQ-025 Mispredict: a branch that resolves with ex_taken_i != ex_pred SHALL drive flush_o=1.
REQ-026 Redirect PC: when flush_o=1, redirect_pc_o=ex_target if ex_taken_i=1, otherwise redirect_pc_o=ex_pc_plus4.
REQ-027 br_count_o SHALL increment by 1 on each resolution and saturate at 16'hFFFF.
REQ-028 mis_count_o SHALL increment by 1 on each flush and saturate at 16'hFFFF.
REQ-029 If a branch resolves correctly in EX while another branch is in ID, the ID branch SHALL be captured normally (back-to-back branches are supported).
REQ-030 PC+4 SHALL wrap at 2^32: id_pc_i=32'hFFFFFFFC yields ex_pc_plus4=0.

Reset
REQ-031 While rst_i=0, all holding-register fields and both counters SHALL be 0, so every output reads 0.
REQ-032 Reset asserted mid-operation (e.g. during a stall or mispredict) SHALL clear state immediately; no resolution is pending after rst_i rises.
REQ-033 The first capture after reset SHALL occur on the first rising edge of clk_i with rst_i=1.

Verification
REQ-034 Correct taken: id_branch=1, pred=1, pc=0x100, target=0x200; next cycle ex_taken=1 -> branch_o=1, update_o=1, result_o=1, flush_o=0, br_count=1, mis_count=0.
REQ-035 Mispredict not-taken: pred=1, pc=0x100, target=0x200, ex_taken=0 -> flush_o=1, redirect_pc_o=0x104, mis_count=1; the ID branch present in that cycle is not captured (ex_valid=0 next cycle).
REQ-036 Mispredict taken: pred=0, target=0x40, ex_taken=1 -> flush_o=1, redirect_pc_o=0x40, update_o=1, result_o=0.
REQ-037 Stall: branch held in EX with stall_i=1 for 3 cycles -> branch_o=0 throughout; exactly one branch_o=1 pulse on the first cycle stall_i=0; br_count increments by 1.
REQ-038 Saturation/wrap: preload 0xFFFF resolutions, then resolve one more -> br_count_o stays 0xFFFF; pc=0xFFFFFFFC mispredicted not-taken -> redirect_pc_o=0.
REQ-039 Reset: rst_i low while ex_valid=1 and a mispredict is pending -> all outputs 0 immediately; no branch_o pulse after rst_i rises.
